// File: rtl/b05_disp_pkg.sv
// b05_disp_pkg: shared constants and types for the b05 display-bus decoder.
//   Segment codes are bit6..bit0. disp_bus_t is the 36-bit display bus payload.
package b05_disp_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned DIG_W = 4;
   localparam int unsigned NDIG  = 5;
   localparam int unsigned MAG_W = 8;
   localparam int unsigned NUM_W = 5;
   localparam int unsigned ERR_W = 8;

   localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b0011000;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b1101100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b1011010;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b1110110;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b1110111;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b0011100;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1000000;

   // Display bus, MSB first: SIGN, DISPMAX1..3, DISPNUM1..2.
   typedef struct packed {
      logic             sign;
      logic [SEG_W-1:0] max1;
      logic [SEG_W-1:0] max2;
      logic [SEG_W-1:0] max3;
      logic [SEG_W-1:0] num1;
      logic [SEG_W-1:0] num2;
   } disp_bus_t;

   typedef enum logic [1:0] {FR_BLANK, FR_DASH, FR_NUM, FR_ILL} frame_cls_e;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_e;

endpackage

// File: rtl/b05_seg2bcd.sv
// b05_seg2bcd: combinational seven-segment to BCD digit decoder.
//   seg_i   : segment pattern, bit6..bit0
//   legal_c : pattern is one of the digits 0..9
//   digit_c : decoded digit (0 when not legal)
module b05_seg2bcd
   import b05_disp_pkg::*;
(
   input  logic [SEG_W-1:0] seg_i,
   output logic             legal_c,
   output logic [DIG_W-1:0] digit_c
);

   always_comb begin
      legal_c = 1'b1;
      digit_c = '0;
      case (seg_i)
         SEG_0:   digit_c = DIG_W'(0);
         SEG_1:   digit_c = DIG_W'(1);
         SEG_2:   digit_c = DIG_W'(2);
         SEG_3:   digit_c = DIG_W'(3);
         SEG_4:   digit_c = DIG_W'(4);
         SEG_5:   digit_c = DIG_W'(5);
         SEG_6:   digit_c = DIG_W'(6);
         SEG_7:   digit_c = DIG_W'(7);
         SEG_8:   digit_c = DIG_W'(8);
         SEG_9:   digit_c = DIG_W'(9);
         default: legal_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/b05_disp_decoder.sv
// b05_disp_decoder: receive-side decoder for the b05 seven-segment display bus.
//   Waits for the bus to be stable for STABLE_CYCLES matching samples, then
//   classifies the frame and emits exactly one registered pulse per capture.
//   Inputs : clk, rst_n (async, active-low), SIGN, DISPMAX1..3, DISPNUM1..2
//   Outputs: frame_valid / dash_seen / dec_err (one-cycle pulses),
//            max_mag (0..199), max_neg, num_val (0..19), busy (in SETTLE)
//   Optional (B05_DISP_ERRCNT_EN): err_clr input, saturating err_cnt output.
module b05_disp_decoder
   import b05_disp_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef B05_DISP_ERRCNT_EN
   input  logic             err_clr,
   output logic [ERR_W-1:0] err_cnt,
`endif
   input  logic             SIGN,
   input  logic [SEG_W-1:0] DISPMAX1,
   input  logic [SEG_W-1:0] DISPMAX2,
   input  logic [SEG_W-1:0] DISPMAX3,
   input  logic [SEG_W-1:0] DISPNUM1,
   input  logic [SEG_W-1:0] DISPNUM2,
   output logic             frame_valid,
   output logic             dash_seen,
   output logic             dec_err,
   output logic [MAG_W-1:0] max_mag,
   output logic             max_neg,
   output logic [NUM_W-1:0] num_val,
   output logic             busy
);

   disp_bus_t        bus_c, bus_q;
   logic             bus_blank_c, same_c;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fv_q, fv_d, ds_q, ds_d, de_q, de_d, busy_q, busy_d;
   logic [MAG_W-1:0] mag_q, mag_d;
   logic             neg_q, neg_d;
   logic [NUM_W-1:0] num_q, num_d;

   logic [SEG_W-1:0] seg_q [NDIG];
   logic [NDIG-1:0]  leg_c;
   logic [DIG_W-1:0] dig_c [NDIG];
   frame_cls_e       cls_c;

   assign bus_c = '{sign: SIGN, max1: DISPMAX1, max2: DISPMAX2, max3: DISPMAX3,
                    num1: DISPNUM1, num2: DISPNUM2};
   assign bus_blank_c = (bus_c == '0);
   assign same_c      = (bus_c == bus_q);

   // Decode the sampled frame; when a capture fires, bus_q equals the live bus.
   assign seg_q[0] = bus_q.max1;
   assign seg_q[1] = bus_q.max2;
   assign seg_q[2] = bus_q.max3;
   assign seg_q[3] = bus_q.num1;
   assign seg_q[4] = bus_q.num2;

   for (genvar g = 0; g < NDIG; g++) begin : g_dec
      b05_seg2bcd u_dec (
         .seg_i   (seg_q[g]),
         .legal_c (leg_c[g]),
         .digit_c (dig_c[g])
      );
   end

   // Frame classification of the sampled bus.
   always_comb begin
      cls_c = FR_ILL;
      if (bus_q == '0) begin
         cls_c = FR_BLANK;
      end else if (bus_q.sign && bus_q.max1 == SEG_DASH && bus_q.max2 == SEG_DASH &&
                   bus_q.max3 == SEG_DASH && bus_q.num1 == SEG_DASH &&
                   bus_q.num2 == SEG_DASH) begin
         cls_c = FR_DASH;
      end else if ((&leg_c) && dig_c[0] <= DIG_W'(1) && dig_c[3] <= DIG_W'(1)) begin
         cls_c = FR_NUM;
      end
   end

   // Next-state, stability counter and capture outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fv_d    = 1'b0;
      ds_d    = 1'b0;
      de_d    = 1'b0;
      mag_d   = mag_q;
      neg_d   = neg_q;
      num_d   = num_q;
      case (state_q)
         S_IDLE: begin
            if (!bus_blank_c) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         S_SETTLE: begin
            if (bus_blank_c) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (!same_c) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = S_HOLD;
               cnt_d   = '0;
               case (cls_c)
                  FR_NUM: begin
                     fv_d  = 1'b1;
                     mag_d = MAG_W'(dig_c[0]) * MAG_W'(100) + MAG_W'(dig_c[1]) * MAG_W'(10)
                             + MAG_W'(dig_c[2]);
                     neg_d = bus_q.sign;
                     num_d = NUM_W'(dig_c[3]) * NUM_W'(10) + NUM_W'(dig_c[4]);
                  end
                  FR_DASH: ds_d = 1'b1;
                  default: de_d = 1'b1;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_HOLD: begin
            if (bus_blank_c) begin
               state_d = S_IDLE;
            end else if (!same_c) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == S_SETTLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bus_q   <= '0;
         fv_q    <= 1'b0;
         ds_q    <= 1'b0;
         de_q    <= 1'b0;
         mag_q   <= '0;
         neg_q   <= 1'b0;
         num_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bus_q   <= bus_c;
         fv_q    <= fv_d;
         ds_q    <= ds_d;
         de_q    <= de_d;
         mag_q   <= mag_d;
         neg_q   <= neg_d;
         num_q   <= num_d;
         busy_q  <= busy_d;
      end
   end

   assign frame_valid = fv_q;
   assign dash_seen   = ds_q;
   assign dec_err     = de_q;
   assign max_mag     = mag_q;
   assign max_neg     = neg_q;
   assign num_val     = num_q;
   assign busy        = busy_q;

`ifdef B05_DISP_ERRCNT_EN
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   // Saturating error counter; clear wins over a same-cycle increment.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = '0;
      end else if (de_d && err_cnt_q != '1) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_b05_disp_decoder.sv
// tb_b05_disp_decoder: randomized + directed bench for b05_disp_decoder.
//   Reference model: a frame is captured when the same non-blank bus value has
//   been sampled on STABLE+1 consecutive clock edges; the capture pulse and the
//   data update appear right after that edge.
module tb_b05_disp_decoder;

   localparam int unsigned STABLE = 2;
   localparam logic [6:0]  DASH   = 7'b1000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        err_clr = 1'b0;
   logic [35:0] bus_v = '0;
   logic        SIGN;
   logic [6:0]  DISPMAX1, DISPMAX2, DISPMAX3, DISPNUM1, DISPNUM2;
   logic        frame_valid, dash_seen, dec_err, max_neg, busy;
   logic [7:0]  max_mag;
   logic [4:0]  num_val;
`ifdef B05_DISP_ERRCNT_EN
   logic [7:0]  err_cnt;
`endif

   always #5 clk = ~clk;

   assign {SIGN, DISPMAX1, DISPMAX2, DISPMAX3, DISPNUM1, DISPNUM2} = bus_v;

   b05_disp_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef B05_DISP_ERRCNT_EN
      .err_clr     (err_clr),
      .err_cnt     (err_cnt),
`endif
      .SIGN        (SIGN),
      .DISPMAX1    (DISPMAX1),
      .DISPMAX2    (DISPMAX2),
      .DISPMAX3    (DISPMAX3),
      .DISPNUM1    (DISPNUM1),
      .DISPNUM2    (DISPNUM2),
      .frame_valid (frame_valid),
      .dash_seen   (dash_seen),
      .dec_err     (dec_err),
      .max_mag     (max_mag),
      .max_neg     (max_neg),
      .num_val     (num_val),
      .busy        (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0011000, 7'b1101100, 7'b1111001,
                                7'b1011010, 7'b1110110, 7'b1110111, 7'b0011100,
                                7'b1111111, 7'b1111110};

   function automatic int dig_of(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
      return -1;
   endfunction

   function automatic logic [35:0] mk_num(input logic sgn, input int mag, input int num);
      return {sgn, seg_tab[mag / 100], seg_tab[(mag / 10) % 10], seg_tab[mag % 10],
              seg_tab[num / 10], seg_tab[num % 10]};
   endfunction

   // Model state and expected outputs.
   logic [35:0] m_prev;
   int          m_run;
   logic        e_fv, e_ds, e_de, e_neg, e_busy;
   int          e_mag, e_num, e_err;

   task automatic model_reset();
      m_prev = '0; m_run = 0;
      e_fv = 0; e_ds = 0; e_de = 0; e_neg = 0; e_busy = 0;
      e_mag = 0; e_num = 0; e_err = 0;
   endtask

   task automatic model_edge(input logic [35:0] b, input logic clr);
      logic [6:0] f [5];
      int         d [5];
      logic       all_dash, all_dig;
      e_fv = 0; e_ds = 0; e_de = 0;
      if (b == m_prev) begin
         if (m_run < 1000) m_run++;
      end else begin
         m_run = 1;
      end
      m_prev = b;
      if (b != '0 && m_run == STABLE + 1) begin
         f[0] = b[34:28]; f[1] = b[27:21]; f[2] = b[20:14]; f[3] = b[13:7]; f[4] = b[6:0];
         all_dash = 1'b1;
         all_dig  = 1'b1;
         for (int i = 0; i < 5; i++) begin
            d[i] = dig_of(f[i]);
            if (f[i] != DASH) all_dash = 1'b0;
            if (d[i] < 0) all_dig = 1'b0;
         end
         if (b[35] && all_dash) begin
            e_ds = 1;
         end else if (all_dig && d[0] <= 1 && d[3] <= 1) begin
            e_fv  = 1;
            e_mag = 100 * d[0] + 10 * d[1] + d[2];
            e_num = 10 * d[3] + d[4];
            e_neg = b[35];
         end else begin
            e_de = 1;
         end
      end
      e_busy = (b != '0) && (m_run <= STABLE);
      if (clr) e_err = 0;
      else if (e_de && e_err < 255) e_err++;
   endtask

   int fv_cnt, ds_cnt, de_cnt, step_no, last_ds_step;

   // One clock: drive at negedge, model at posedge, compare just after.
   task automatic step(input logic [35:0] b, input logic r = 1'b1, input logic c = 1'b0);
      @(negedge clk);
      bus_v   = b;
      rst_n   = r;
      err_clr = c;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge(b, c);
      #1;
      step_no++;
      check("frame_valid", 32'(frame_valid), 32'(e_fv));
      check("dash_seen", 32'(dash_seen), 32'(e_ds));
      check("dec_err", 32'(dec_err), 32'(e_de));
      check("max_mag", 32'(max_mag), 32'(e_mag));
      check("max_neg", 32'(max_neg), 32'(e_neg));
      check("num_val", 32'(num_val), 32'(e_num));
      check("busy", 32'(busy), 32'(e_busy));
`ifdef B05_DISP_ERRCNT_EN
      check("err_cnt", 32'(err_cnt), 32'(e_err));
`endif
      if (frame_valid) fv_cnt++;
      if (dash_seen) begin ds_cnt++; last_ds_step = step_no; end
      if (dec_err) de_cnt++;
   endtask

   task automatic clr_counts();
      fv_cnt = 0; ds_cnt = 0; de_cnt = 0; step_no = 0; last_ds_step = -1;
   endtask

   logic [35:0] f_dash, f_050, f_glitch, f_ill, f_rand;
   int          start_mag;

   initial begin
      model_reset();
      clr_counts();
      f_dash = {1'b1, DASH, DASH, DASH, DASH, DASH};
      f_050  = mk_num(1'b0, 50, 7);

      // Reset with a quiet bus.
      repeat (3) step('0, 1'b0);
      clr_counts();
      repeat (20) step('0);
      check("reset_pulses", 32'(fv_cnt + ds_cnt + de_cnt), 32'd0);

      // Dash frame: one pulse on the third clock, data untouched.
      clr_counts();
      repeat (5) step(f_dash);
      check("dash_count", 32'(ds_cnt), 32'd1);
      check("dash_latency", 32'(last_ds_step), 32'd3);
      check("dash_mag", 32'(max_mag), 32'd0);
      repeat (2) step('0);

      // Numeric 050 / 07.
      clr_counts();
      repeat (5) step(f_050);
      check("num_count", 32'(fv_cnt), 32'd1);
      check("num_mag50", 32'(max_mag), 32'd50);
      check("num_val7", 32'(num_val), 32'd7);
      repeat (2) step('0);

      // One-cycle glitch on DISPMAX3 inside SETTLE.
      f_glitch = f_050;
      f_glitch[20:14] = 7'b1111111;
      clr_counts();
      step(f_050);
      step(f_glitch);
      repeat (5) step(f_050);
      check("glitch_count", 32'(fv_cnt), 32'd1);
      check("glitch_mag", 32'(max_mag), 32'd50);
      repeat (2) step('0);

      // Illegal tens digit; data retained.
      f_ill = f_050;
      f_ill[27:21] = 7'b0000001;
      clr_counts();
      repeat (5) step(f_ill);
      check("ill_count", 32'(de_cnt), 32'd1);
      check("ill_mag_kept", 32'(max_mag), 32'd50);
      step('0);
`ifdef B05_DISP_ERRCNT_EN
      check("errcnt_one", 32'(err_cnt), 32'd1);
      step(f_ill);
      step(f_ill);
      step(f_ill, 1'b1, 1'b1);
      check("errcnt_clr_wins", 32'(err_cnt), 32'd0);
      step('0);
`endif

      // Same frame after a one-cycle blank gap is captured twice.
      clr_counts();
      start_mag = 123;
      repeat (4) step(mk_num(1'b1, start_mag, 19));
      step('0);
      repeat (4) step(mk_num(1'b1, start_mag, 19));
      check("regap_count", 32'(fv_cnt), 32'd2);
      step('0);

      // Reset during SETTLE suppresses the pending capture.
      clr_counts();
      repeat (2) step(mk_num(1'b0, 199, 0));
      step('0, 1'b0);
      repeat (4) step('0);
      check("rst_settle_count", 32'(fv_cnt), 32'd0);

      // Randomized frames held for random durations.
      repeat (400) begin
         case ($urandom_range(0, 5))
            0: f_rand = '0;
            1: f_rand = f_dash;
            2: f_rand = {$urandom_range(0, 1) == 1, 35'($urandom)};
            3: f_rand = {1'b0, DASH, DASH, DASH, DASH, DASH};
            default: f_rand = mk_num($urandom_range(0, 1) == 1, $urandom_range(0, 199),
                                     $urandom_range(0, 19));
         endcase
         repeat ($urandom_range(1, 5)) begin
            if ($urandom_range(0, 60) == 0) step(f_rand, 1'b0);
            else step(f_rand, 1'b1, $urandom_range(0, 15) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
